// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: owns the PC, stalls on multiplies and bne resolution,
// and inserts flush bubbles after taken jumps/branches.
module pipe_sequencer #(
    parameter int unsigned MUL_CYCLES   = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic        mul_start,
    input  logic        jmp_flag,
    input  logic [31:0] jmp_address,
    input  logic        branch_flag,
    input  logic [15:0] branch_offset,
    input  logic        alu_zero,
    output logic [31:0] pc,
    output logic        stall,
    output logic        flush,
    output logic        mul_go,
    output logic        mul_wb,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StMulWait   = 2'd1,
        StBrResolve = 2'd2,
        StFlush     = 2'd3
    } state_e;

    localparam logic [7:0] MulLoad   = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] FlushLoad = 8'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] br_pc_q, br_pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mul_go_q, mul_go_d;

    logic        jmp_req, br_req, mul_req;
    logic [31:0] br_off_ext;

    // Priority jump > branch > mul, all gated by a valid decode slot.
    assign jmp_req    = instr_valid & jmp_flag;
    assign br_req     = instr_valid & branch_flag & ~jmp_flag;
    assign mul_req    = instr_valid & mul_start & ~jmp_flag & ~branch_flag;
    assign br_off_ext = {{16{branch_offset[15]}}, branch_offset};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        br_pc_d  = br_pc_q;
        cnt_d    = cnt_q;
        mul_go_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (jmp_req) begin
                    pc_d    = jmp_address;
                    cnt_d   = FlushLoad;
                    state_d = StFlush;
                end else if (br_req) begin
                    br_pc_d = pc_q;
                    state_d = StBrResolve;
                end else if (mul_req) begin
                    cnt_d    = MulLoad;
                    mul_go_d = 1'b1;
                    state_d  = StMulWait;
                end else begin
                    pc_d = pc_q + 32'd1;
                end
            end
            StMulWait: begin
                if (cnt_q == 8'd0) begin
                    pc_d    = pc_q + 32'd1;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StBrResolve: begin
                // bne is taken when the operands differ.
                if (!alu_zero) begin
                    pc_d    = br_pc_q + 32'd1 + br_off_ext;
                    cnt_d   = FlushLoad;
                    state_d = StFlush;
                end else begin
                    pc_d    = br_pc_q + 32'd1;
                    state_d = StRun;
                end
            end
            StFlush: begin
                if (cnt_q == 8'd0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            pc_q     <= RESET_PC;
            br_pc_q  <= 32'd0;
            cnt_q    <= 8'd0;
            mul_go_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            br_pc_q  <= br_pc_d;
            cnt_q    <= cnt_d;
            mul_go_q <= mul_go_d;
        end
    end

    assign pc     = pc_q;
    assign stall  = (state_q == StMulWait) | (state_q == StBrResolve);
    assign flush  = (state_q == StFlush);
    assign mul_go = mul_go_q;
    assign mul_wb = (state_q == StMulWait) & (cnt_q == 8'd0);
    assign state  = state_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench: a queue of expected per-cycle outputs is built from each
// accepted instruction and compared against the sequencer every cycle.
module tb_pipe_sequencer;

    localparam int unsigned MC  = 16;
    localparam int unsigned FC  = 2;
    localparam logic [31:0] RPC = 32'd0;

    logic        clk = 1'b0;
    logic        rst, instr_valid, mul_start, jmp_flag, branch_flag, alu_zero;
    logic [31:0] jmp_address;
    logic [15:0] branch_offset;
    logic [31:0] pc;
    logic        stall, flush, mul_go, mul_wb;
    logic [1:0]  state;

    pipe_sequencer #(
        .MUL_CYCLES  (MC),
        .FLUSH_CYCLES(FC),
        .RESET_PC    (RPC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .mul_start    (mul_start),
        .jmp_flag     (jmp_flag),
        .jmp_address  (jmp_address),
        .branch_flag  (branch_flag),
        .branch_offset(branch_offset),
        .alu_zero     (alu_zero),
        .pc           (pc),
        .stall        (stall),
        .flush        (flush),
        .mul_go       (mul_go),
        .mul_wb       (mul_wb),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        go;
        logic        wb;
        logic [1:0]  st;
    } obs_t;

    obs_t        exp_q[$];
    logic [31:0] mpc;
    logic        hold_az;
    logic [15:0] hold_off;
    int          nchk = 0;
    int          nerr = 0;

    function automatic obs_t exp_now();
        obs_t e;
        if (exp_q.size() != 0) e = exp_q[0];
        else e = '{pc: mpc, stall: 1'b0, flush: 1'b0, go: 1'b0, wb: 1'b0, st: 2'd0};
        return e;
    endfunction

    function automatic obs_t cur_obs();
        obs_t g;
        g = '{pc: pc, stall: stall, flush: flush, go: mul_go, wb: mul_wb, st: state};
        return g;
    endfunction

    function automatic void push_flush(input logic [31:0] tgt);
        for (int i = 0; i < int'(FC); i++)
            exp_q.push_back('{pc: tgt, stall: 1'b0, flush: 1'b1, go: 1'b0, wb: 1'b0, st: 2'd3});
    endfunction

    // Drives one cycle of inputs, advances the model, and lands #1 after the edge.
    task automatic cycle(input logic r, input logic v, input logic m, input logic j,
                         input logic [31:0] a, input logic b, input logic [15:0] off,
                         input logic az);
        logic [31:0] tgt;
        rst = r; instr_valid = v; mul_start = m; jmp_flag = j; jmp_address = a;
        branch_flag = b; branch_offset = off; alu_zero = az;
        if (exp_q.size() != 0 && exp_q[0].st == 2'd2) begin
            branch_offset = hold_off;
            alu_zero      = hold_az;
        end
        if (r) begin
            exp_q.delete();
            mpc = RPC;
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (v && j) begin
            push_flush(a);
            mpc = a;
        end else if (v && b) begin
            hold_az  = az;
            hold_off = off;
            exp_q.push_back('{pc: mpc, stall: 1'b1, flush: 1'b0, go: 1'b0, wb: 1'b0, st: 2'd2});
            if (!az) begin
                tgt = mpc + 32'd1 + {{16{off[15]}}, off};
                push_flush(tgt);
                mpc = tgt;
            end else begin
                mpc = mpc + 32'd1;
            end
        end else if (v && m) begin
            for (int i = 0; i < int'(MC); i++)
                exp_q.push_back('{pc: mpc, stall: 1'b1, flush: 1'b0, go: (i == 0),
                                  wb: (i == int'(MC) - 1), st: 2'd1});
            mpc = mpc + 32'd1;
        end else begin
            mpc = mpc + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic jump_to(input logic [31:0] a);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, a, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < int'(FC); i++) idle();
    endtask

    task automatic test_reset();
        obs_t g, e;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        g = cur_obs(); e = exp_now(); nchk++;
        if (g !== e) begin nerr++; $display("FAIL reset: got %h want %h", g, e); end
        for (int i = 1; i <= 4; i++) begin
            idle();
            g = cur_obs(); e = exp_now(); nchk++;
            if (g !== e) begin nerr++; $display("FAIL idle[%0d]: got %h want %h", i, g, e); end
        end
        nchk++;
        if (pc !== 32'd4) begin nerr++; $display("FAIL idle_pc: got %0d want 4", pc); end
    endtask

    task automatic test_mul();
        obs_t g, e;
        int n_stall = 0, n_go = 0, n_wb = 0;
        idle();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < int'(MC); i++) begin
            g = cur_obs(); e = exp_now(); nchk++;
            if (g !== e) begin nerr++; $display("FAIL mul[%0d]: got %h want %h", i, g, e); end
            n_stall += int'(stall); n_go += int'(mul_go); n_wb += int'(mul_wb);
            idle();
        end
        g = cur_obs(); e = exp_now(); nchk++;
        if (g !== e || pc !== 32'd6) begin
            nerr++; $display("FAIL mul_done: got %h want %h (pc 6)", g, e);
        end
        nchk++;
        if (n_stall != int'(MC) || n_go != 1 || n_wb != 1) begin
            nerr++;
            $display("FAIL mul_counts: stall=%0d go=%0d wb=%0d want %0d/1/1", n_stall, n_go,
                     n_wb, MC);
        end
    endtask

    task automatic test_jump();
        obs_t g, e;
        idle();
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < int'(FC) + 2; i++) begin
            g = cur_obs(); e = exp_now(); nchk++;
            if (g !== e) begin nerr++; $display("FAIL jump[%0d]: got %h want %h", i, g, e); end
            idle();
        end
        nchk++;
        if (pc !== 32'h102) begin nerr++; $display("FAIL jump_pc: got %h want 102", pc); end
    endtask

    task automatic test_branch(input logic az);
        obs_t g, e;
        jump_to(32'd10);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 16'hFFFC, az);
        for (int i = 0; i < int'(FC) + 3; i++) begin
            g = cur_obs(); e = exp_now(); nchk++;
            if (g !== e) begin
                nerr++; $display("FAIL branch az=%0b [%0d]: got %h want %h", az, i, g, e);
            end
            if (i == 1) begin
                nchk++;
                if (pc !== (az ? 32'd11 : 32'd7)) begin
                    nerr++; $display("FAIL branch_pc az=%0b: got %0d want %0d", az, pc,
                                     az ? 11 : 7);
                end
            end
            idle();
        end
    endtask

    task automatic test_priority();
        obs_t g, e;
        int bad = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 16'h0005, 1'b0);
        for (int i = 0; i < int'(FC) + 2; i++) begin
            g = cur_obs(); e = exp_now(); nchk++;
            if (g !== e) begin nerr++; $display("FAIL prio[%0d]: got %h want %h", i, g, e); end
            if (state === 2'd2 || mul_go !== 1'b0) bad++;
            idle();
        end
        nchk++;
        if (bad != 0) begin nerr++; $display("FAIL prio_excl: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_wrap();
        obs_t g, e;
        jump_to(32'hFFFF_FFFF);
        g = cur_obs(); e = exp_now(); nchk++;
        if (g !== e) begin nerr++; $display("FAIL wrap_pre: got %h want %h", g, e); end
        idle();
        nchk++;
        if (pc !== 32'd0) begin nerr++; $display("FAIL wrap: got %h want 0", pc); end
    endtask

    task automatic test_reset_in_mul();
        obs_t g, e;
        int n_wb = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_wb += int'(mul_wb);
            idle();
        end
        nchk++;
        if (state !== 2'd1) begin nerr++; $display("FAIL rmul_pre: got st %0d want 1", state); end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        g = cur_obs(); e = exp_now(); nchk++;
        if (g !== e || pc !== RPC || stall !== 1'b0) begin
            nerr++; $display("FAIL rmul_reset: got %h want %h", g, e);
        end
        for (int i = 0; i < int'(MC) + 2; i++) begin
            n_wb += int'(mul_wb);
            idle();
        end
        nchk++;
        if (n_wb != 0) begin nerr++; $display("FAIL rmul_wb: got %0d pulses want 0", n_wb); end
    endtask

    task automatic test_random();
        obs_t g, e;
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), $urandom(),
                  ($urandom_range(0, 6) == 0), 16'($urandom()), 1'($urandom()));
            g = cur_obs(); e = exp_now(); nchk++;
            if (g !== e) begin nerr++; $display("FAIL rand[%0d]: got %h want %h", i, g, e); end
        end
    endtask

    initial begin
        mpc = RPC; hold_az = 1'b0; hold_off = 16'd0;
        rst = 1'b1; instr_valid = 1'b0; mul_start = 1'b0; jmp_flag = 1'b0;
        jmp_address = 32'd0; branch_flag = 1'b0; branch_offset = 16'd0; alu_zero = 1'b0;
        @(negedge clk);
        test_reset();
        test_mul();
        test_jump();
        test_branch(1'b0);
        test_branch(1'b1);
        test_priority();
        test_wrap();
        test_reset_in_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
